sys_cmd_ctrl: RTL
=================

Name: sys_cmd_ctrl

Overview:
Command controller between the UART receiver (after the RX data synchronizer) and the register file, ALU and TX FIFO of the low-power system. It parses byte-stream frames (0xAA write, 0xBB read, 0xCC ALU with operands, 0xDD ALU without operands) and drives RF and ALU strobes. It returns read and ALU results as bytes into the TX FIFO and gates the ALU clock when the ALU is idle.

Parameters:
DATA_W, 8, byte width of RX/TX/RF data
ADDR_W, 4, register-file address width; the address byte is truncated to its low ADDR_W bits
ALU_FUN_W, 4, ALU function-code width; the function byte is truncated to its low ALU_FUN_W bits
OPA_ADDR, 0, RF address for operand A
OPB_ADDR, 1, RF address for operand B

Ports:
CLK  in  1  system clock (REF_CLK domain)
RST  in  1  synchronous active-high reset
RX_P_DATA  in  DATA_W  received byte, valid only when RX_D_VLD=1
RX_D_VLD  in  1  one-cycle pulse per received byte
RF_ADDR  out  ADDR_W  register-file address
RF_WR_EN  out  1  one-cycle write strobe
RF_WR_DATA  out  DATA_W  write data
RF_RD_EN  out  1  one-cycle read strobe
RF_RD_DATA  in  DATA_W  read data
RF_RD_VLD  in  1  read data valid; arrives 1 or more cycles after RF_RD_EN
ALU_FUN  out  ALU_FUN_W  ALU function code
ALU_EN  out  1  one-cycle ALU start strobe
ALU_CLK_EN  out  1  ALU clock-gate enable
ALU_OUT  in  2*DATA_W  ALU result
ALU_OUT_VLD  in  1  ALU result valid; arrives 1 or more cycles after ALU_EN
TX_P_DATA  out  DATA_W  byte pushed to the TX FIFO
TX_D_VLD  out  1  FIFO write strobe; must be 0 while FIFO_FULL=1
FIFO_FULL  in  1  TX FIFO full
BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset values:
  - all strobes 0
  - RF_ADDR, RF_WR_DATA, ALU_FUN and TX_P_DATA are 0
  - ALU_CLK_EN 0, BUSY 0
  - state IDLE
- Reset in any state aborts the frame immediately. No further strobes are issued.
- FSM states:
  - IDLE
  - WR_ADDR, WR_DATA
  - RD_ADDR, RD_WAIT
  - OPA, OPB, FUN
  - ALU_WAIT
  - TX_LO, TX_HI
- State transitions occur only on RX_D_VLD in the byte-collecting states.
- IDLE:
  - 0xAA goes to WR_ADDR.
  - 0xBB goes to RD_ADDR.
  - 0xCC goes to OPA.
  - 0xDD goes to FUN.
  - Any other byte is dropped and the FSM stays in IDLE.
- Write frame (0xAA):
  - WR_ADDR latches the address byte.
  - WR_DATA: on the data byte, the next cycle asserts RF_WR_EN=1 for exactly one cycle, with RF_ADDR and RF_WR_DATA stable in that cycle. The FSM then returns to IDLE.
- Read frame (0xBB):
  - RD_ADDR: on the address byte, the next cycle asserts RF_RD_EN for one cycle, then the FSM enters RD_WAIT.
  - RD_WAIT: on RF_RD_VLD, capture RF_RD_DATA into TX_LO as a single byte, then return to IDLE.
- Operand ALU frame (0xCC):
  - OPA: the byte is written to OPA_ADDR with a one-cycle RF_WR_EN.
  - OPB: the byte is written to OPB_ADDR with a one-cycle RF_WR_EN.
  - The FSM then continues to FUN.
- FUN:
  - Latch ALU_FUN.
  - Assert ALU_CLK_EN.
  - In the next cycle, assert ALU_EN for one cycle.
  - Enter ALU_WAIT.
- ALU_WAIT: on ALU_OUT_VLD, capture ALU_OUT and go to TX_LO.
- TX_LO / TX_HI:
  - A TX byte is pushed only when FIFO_FULL=0. Each push is a one-cycle TX_D_VLD with TX_P_DATA stable.
  - For read results, TX_LO sends the byte and returns to IDLE.
  - For ALU results, TX_LO sends ALU_OUT[DATA_W-1:0], then TX_HI sends ALU_OUT[2*DATA_W-1:DATA_W], then return to IDLE.
  - While FIFO_FULL=1, the FSM holds and retains the pending byte.
- ALU_CLK_EN:
  - Asserted from the FUN byte until the ALU result is captured.
  - Low otherwise, including during all RF-only frames.
- RX_D_VLD in wait, strobe or TX states is ignored; the byte is lost. Senders must not pipeline frames.
- An RX byte arriving in the same cycle as FIFO_FULL deasserts is handled independently; there is no interaction.
- No timeout exists. A truncated frame is completed by whatever bytes arrive next.

Test Plan:
- Write frame 0xAA,0x02,0x21 -> exactly one RF_WR_EN pulse with RF_ADDR=2, RF_WR_DATA=0x21; no TX_D_VLD; BUSY returns to 0.
- Read frame 0xBB,0x07 with RF_RD_DATA=0xCD returned 2 cycles after RF_RD_EN -> one RF_RD_EN pulse with RF_ADDR=7; one TX_D_VLD with TX_P_DATA=0xCD.
- Operand ALU frame 0xCC,0x0A,0x04,0x00 with ALU model returning 0x000E -> RF writes (0,0x0A) then (1,0x04); ALU_EN with ALU_FUN=0; TX bytes 0x0E then 0x00; ALU_CLK_EN high only over that window.
- No-operand ALU frame 0xDD,0x02 with ALU_OUT=0x0028 -> no RF writes; ALU_FUN=2; TX bytes 0x28, 0x00.
- FIFO_FULL held for 10 cycles during TX_HI -> TX_D_VLD stays 0 and TX_P_DATA is held; exactly one push after FIFO_FULL falls. A junk byte 0x55 in IDLE produces no strobes.
- RST asserted mid-way through a 0xCC frame after OPA -> all outputs at reset values the next cycle; a following 0xAA frame executes normally.

Source files
------------

// File: rtl/sys_cmd_ctrl.sv
// Frame parser between the UART RX path and the RF / ALU / TX FIFO.
// Registered strobes; TX_D_VLD is combinational so it can never overrun FIFO_FULL.
module sys_cmd_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int ALU_FUN_W = 4,
  parameter int OPA_ADDR  = 0,
  parameter int OPB_ADDR  = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATA_W-1:0]      RX_P_DATA,
  input  logic                   RX_D_VLD,
  output logic [ADDR_W-1:0]      RF_ADDR,
  output logic                   RF_WR_EN,
  output logic [DATA_W-1:0]      RF_WR_DATA,
  output logic                   RF_RD_EN,
  input  logic [DATA_W-1:0]      RF_RD_DATA,
  input  logic                   RF_RD_VLD,
  output logic [ALU_FUN_W-1:0]   ALU_FUN,
  output logic                   ALU_EN,
  output logic                   ALU_CLK_EN,
  input  logic [2*DATA_W-1:0]    ALU_OUT,
  input  logic                   ALU_OUT_VLD,
  output logic [DATA_W-1:0]      TX_P_DATA,
  output logic                   TX_D_VLD,
  input  logic                   FIFO_FULL,
  output logic                   BUSY
);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
    OPA, OPB, FUN, ALU_WAIT, TX_LO, TX_HI
  } state_t;

  state_t state, nxt;
  logic [DATA_W-1:0] hi_q;
  logic              two_q;
  logic              tx_st;

  assign tx_st    = (state == TX_LO) || (state == TX_HI);
  assign TX_D_VLD = tx_st && !FIFO_FULL;
  assign BUSY     = (state != IDLE);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (RX_D_VLD) begin
        case (RX_P_DATA)
          8'hAA:   nxt = WR_ADDR;
          8'hBB:   nxt = RD_ADDR;
          8'hCC:   nxt = OPA;
          8'hDD:   nxt = FUN;
          default: nxt = IDLE;
        endcase
      end
      WR_ADDR:  if (RX_D_VLD) nxt = WR_DATA;
      WR_DATA:  if (RX_D_VLD) nxt = IDLE;
      RD_ADDR:  if (RX_D_VLD) nxt = RD_WAIT;
      RD_WAIT:  if (RF_RD_VLD) nxt = TX_LO;
      OPA:      if (RX_D_VLD) nxt = OPB;
      OPB:      if (RX_D_VLD) nxt = FUN;
      FUN:      if (RX_D_VLD) nxt = ALU_WAIT;
      ALU_WAIT: if (ALU_OUT_VLD) nxt = TX_LO;
      TX_LO:    if (!FIFO_FULL) nxt = two_q ? TX_HI : IDLE;
      TX_HI:    if (!FIFO_FULL) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      RF_ADDR    <= '0;
      RF_WR_EN   <= 1'b0;
      RF_WR_DATA <= '0;
      RF_RD_EN   <= 1'b0;
      ALU_FUN    <= '0;
      ALU_EN     <= 1'b0;
      ALU_CLK_EN <= 1'b0;
      TX_P_DATA  <= '0;
      hi_q       <= '0;
      two_q      <= 1'b0;
    end else begin
      state    <= nxt;
      RF_WR_EN <= 1'b0;
      RF_RD_EN <= 1'b0;
      ALU_EN   <= 1'b0;
      unique case (state)
        WR_ADDR: if (RX_D_VLD) RF_ADDR <= RX_P_DATA[ADDR_W-1:0];
        WR_DATA: if (RX_D_VLD) begin
          RF_WR_DATA <= RX_P_DATA;
          RF_WR_EN   <= 1'b1;
        end
        RD_ADDR: if (RX_D_VLD) begin
          RF_ADDR  <= RX_P_DATA[ADDR_W-1:0];
          RF_RD_EN <= 1'b1;
        end
        RD_WAIT: if (RF_RD_VLD) begin
          TX_P_DATA <= RF_RD_DATA;
          two_q     <= 1'b0;
        end
        OPA: if (RX_D_VLD) begin
          RF_ADDR    <= ADDR_W'(OPA_ADDR);
          RF_WR_DATA <= RX_P_DATA;
          RF_WR_EN   <= 1'b1;
        end
        OPB: if (RX_D_VLD) begin
          RF_ADDR    <= ADDR_W'(OPB_ADDR);
          RF_WR_DATA <= RX_P_DATA;
          RF_WR_EN   <= 1'b1;
        end
        FUN: if (RX_D_VLD) begin
          ALU_FUN    <= RX_P_DATA[ALU_FUN_W-1:0];
          ALU_EN     <= 1'b1;
          ALU_CLK_EN <= 1'b1;
        end
        ALU_WAIT: if (ALU_OUT_VLD) begin
          TX_P_DATA  <= ALU_OUT[DATA_W-1:0];
          hi_q       <= ALU_OUT[2*DATA_W-1:DATA_W];
          two_q      <= 1'b1;
          ALU_CLK_EN <= 1'b0;
        end
        // the high byte is staged only once the low byte has left
        TX_LO: if (!FIFO_FULL && two_q) TX_P_DATA <= hi_q;
        default: ;
      endcase
    end
  end

endmodule
